crc3_serial_checker: RTL and testbench
======================================

Name: crc3_serial_checker

Overview:
Receive-side counterpart of the CRC-3 encoder. Accepts a 17-bit codeword bit-serially, MSB first: 14 user-data bits followed by 3 CRC bits. The block performs bit-serial polynomial division and presents the recovered 14-bit data word with a pass/fail flag and the 3-bit syndrome. It sits at the input port of the CRC interface, after the channel and before the user-data consumer.

Parameters:
MSG_LENGTH, 17, total codeword bits (data plus CRC).
POLINOMIAL_LENGTH, 4, generator polynomial bits. CRC width CW = POLINOMIAL_LENGTH-1 = 3. Data width DW = MSG_LENGTH-CW = 14.
ERR_CNT_W, 8, width of the saturating error counter.

Ports:
clk  in  1  single clock; all state updates on rising edge.
rst_n  in  1  asynchronous, active-low reset.
polinom  in  POLINOMIAL_LENGTH  generator coefficients, binary; sampled on the first bit of each frame.
rx_sof  in  1  qualifies rx_bit as the first bit of a frame; valid only with rx_valid.
rx_bit  in  1  serial codeword bit, MSB first.
rx_valid  in  1  rx_bit is valid this cycle.
rx_ready  out  1  block accepts a bit this cycle.
data_out  out  DW  recovered user data, codeword bits [16:3].
syndrome  out  CW  division remainder; 0 means the codeword is clean.
crc_ok  out  1  syndrome == 0.
out_valid  out  1  result is held and valid.
out_ready  in  1  consumer accepts the result.
err_cnt  out  ERR_CNT_W  number of accepted results with crc_ok=0; saturates at all-ones.

Behaviour:
- Reset (async assert, sync release): state=RECV; bit counter=0; remainder r=0; shift register=0; poly register=0. Outputs reset to: data_out=0, syndrome=0, crc_ok=0, out_valid=0, err_cnt=0, rx_ready=1.
- rx_ready = (state==RECV). A bit transfers when rx_valid && rx_ready.
- States:
  - RECV: accepts bits.
  - HOLD: out_valid=1; outputs stable until out_ready.
- Transitions:
  - RECV -> HOLD on the accepted bit that makes the count reach MSG_LENGTH.
  - HOLD -> RECV on out_valid && out_ready.
- The first bit can be accepted the cycle after leaving HOLD. rx_ready is low during the handshake cycle, so a bit and a result never transfer in the same cycle.
- Division step, per accepted bit b:
  - t = {r, b}, 4 bits.
  - If t[3]==1 then t = t ^ poly.
  - r <= t[2:0].
  - Data shift register <= {sreg[DW-2:0], b} while count < DW.
  - count <= count+1.
  - When t[3]==1 and poly[3]==0, the XOR is still applied to the lower bits and t[3] is discarded; this matches the encoder.
- Frame start:
  - Triggered by an accepted bit with rx_sof=1, or by an accepted bit with count==0.
  - poly <= polinom.
  - r is computed from r=0, i.e. t = {3'b000, b}.
  - count <= 1.
- rx_sof with count!=0: the partial frame is discarded, no result is produced, and a new frame starts with this bit. rx_sof is ignored in HOLD because no transfer occurs.
- Completion (17th bit):
  - data_out <= shift register; syndrome <= final r; crc_ok <= (final r == 0); out_valid <= 1.
  - count <= 0.
  - Latency: result visible the cycle after the 17th bit is accepted.
- err_cnt increments on the HOLD handshake when crc_ok=0; it holds at 2^ERR_CNT_W-1.
- polinom changes mid-frame have no effect.
- rx_bit, rx_sof and out_ready are don't-care when not qualified.
- Reset asserted mid-frame or in HOLD: immediate return to reset values; the partial frame and pending result are lost. err_cnt clears.

Test Plan:
- Clean frame: polinom=4'b1011, stream 17'h1A764 MSB first, rx_valid continuous. Expect rx_ready low exactly 1 cycle after bit 17; then data_out=14'h34EC, syndrome=3'b000, crc_ok=1, out_valid=1, err_cnt=0 after handshake.
- Single-bit error: same frame with LSB flipped (17'h1A765). Expect syndrome=3'b001, crc_ok=0, data_out=14'h34EC; err_cnt=1 after out_ready.
- Backpressure: hold out_ready=0 for 10 cycles after the result. Expect outputs stable and rx_ready=0 throughout; rx_valid bits presented meanwhile are not consumed. Assert out_ready: out_valid drops the next cycle and rx_ready rises.
- Gapped input: toggle rx_valid randomly across the clean frame. Result identical to test 1. Change polinom to 4'b1101 after bit 5: still syndrome=0.
- Resync: send 9 bits of garbage, then rx_sof with the clean frame. Exactly one result, syndrome=0. Reset mid-frame at bit 8, then a full clean frame: single correct result.
- Saturation: ERR_CNT_W=2, four corrupted frames. err_cnt sequence 1,2,3,3.

Source files
------------

// File: rtl/crc3_serial_checker.sv
// CRC-3 serial checker: receives a codeword MSB first, divides it bit-serially
// by the generator polynomial, and holds the recovered data word, the
// syndrome and a pass/fail flag until the consumer takes the result.
// A saturating counter tracks how many failing results were handed over.
module crc3_serial_checker #(
    parameter int MSG_LENGTH        = 17,
    parameter int POLINOMIAL_LENGTH = 4,
    parameter int ERR_CNT_W         = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [POLINOMIAL_LENGTH-1:0]   polinom,
    input  logic                           rx_sof,
    input  logic                           rx_bit,
    input  logic                           rx_valid,
    output logic                           rx_ready,
    output logic [MSG_LENGTH-POLINOMIAL_LENGTH:0] data_out,
    output logic [POLINOMIAL_LENGTH-2:0]   syndrome,
    output logic                           crc_ok,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [ERR_CNT_W-1:0]           err_cnt
);

    localparam int CW    = POLINOMIAL_LENGTH - 1;
    localparam int DW    = MSG_LENGTH - CW;
    localparam int CNT_W = $clog2(MSG_LENGTH + 1);

    typedef enum logic [0:0] {
        RECV = 1'b0,
        HOLD = 1'b1
    } state_t;

    // One long-division step: append the new bit, subtract the generator when
    // the top bit is set. The top bit is dropped even if the generator's own
    // top coefficient is zero, which keeps us bit-compatible with the encoder.
    function automatic logic [CW-1:0] div_step(
        input logic [CW-1:0]                rem,
        input logic                         b,
        input logic [POLINOMIAL_LENGTH-1:0] p
    );
        logic [POLINOMIAL_LENGTH-1:0] t;
        t = {rem, b};
        if (t[CW]) begin
            t = t ^ p;
        end else begin
            t = t;
        end
        return t[CW-1:0];
    endfunction

    state_t                         state_r;
    logic [CNT_W-1:0]               count_r;
    logic [CW-1:0]                  rem_r;
    logic [DW-1:0]                  sreg_r;
    logic [POLINOMIAL_LENGTH-1:0]   poly_r;

    logic                           accept_s;
    logic                           start_s;
    logic [POLINOMIAL_LENGTH-1:0]   poly_use_s;
    logic [CW-1:0]                  rem_in_s;
    logic [CW-1:0]                  rem_next_s;
    logic [CNT_W-1:0]               cnt_base_s;
    logic                           last_s;
    logic [DW-1:0]                  sreg_next_s;
    logic                           err_sat_s;

    // Datapath for the bit being accepted this cycle: frame-start handling,
    // next remainder, next shift-register value and end-of-frame detection.
    always_comb begin
        accept_s    = rx_valid && rx_ready;
        start_s     = rx_sof || (count_r == {CNT_W{1'b0}});
        poly_use_s  = start_s ? polinom : poly_r;
        rem_in_s    = start_s ? {CW{1'b0}} : rem_r;
        rem_next_s  = div_step(rem_in_s, rx_bit, poly_use_s);
        cnt_base_s  = start_s ? {CNT_W{1'b0}} : count_r;
        last_s      = (cnt_base_s == CNT_W'(MSG_LENGTH - 1));
        err_sat_s   = (err_cnt == {ERR_CNT_W{1'b1}});
        if (start_s) begin
            sreg_next_s = {{(DW-1){1'b0}}, rx_bit};
        end else if (count_r < CNT_W'(DW)) begin
            sreg_next_s = {sreg_r[DW-2:0], rx_bit};
        end else begin
            sreg_next_s = sreg_r;
        end
    end

    // Receive/hold controller with all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= RECV;
            count_r   <= {CNT_W{1'b0}};
            rem_r     <= {CW{1'b0}};
            sreg_r    <= {DW{1'b0}};
            poly_r    <= {POLINOMIAL_LENGTH{1'b0}};
            data_out  <= {DW{1'b0}};
            syndrome  <= {CW{1'b0}};
            crc_ok    <= 1'b0;
            out_valid <= 1'b0;
            err_cnt   <= {ERR_CNT_W{1'b0}};
            rx_ready  <= 1'b1;
        end else begin
            case (state_r)
                RECV: begin
                    if (accept_s) begin
                        rem_r  <= rem_next_s;
                        sreg_r <= sreg_next_s;
                        if (start_s) begin
                            poly_r <= polinom;
                        end else begin
                            poly_r <= poly_r;
                        end
                        if (last_s) begin
                            count_r   <= {CNT_W{1'b0}};
                            data_out  <= sreg_next_s;
                            syndrome  <= rem_next_s;
                            crc_ok    <= (rem_next_s == {CW{1'b0}});
                            out_valid <= 1'b1;
                            rx_ready  <= 1'b0;
                            state_r   <= HOLD;
                        end else begin
                            count_r   <= cnt_base_s + CNT_W'(1);
                        end
                    end else begin
                        state_r <= RECV;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        rx_ready  <= 1'b1;
                        state_r   <= RECV;
                        if (!crc_ok && !err_sat_s) begin
                            err_cnt <= err_cnt + ERR_CNT_W'(1);
                        end else begin
                            err_cnt <= err_cnt;
                        end
                    end else begin
                        state_r <= HOLD;
                    end
                end
                default: begin
                    state_r   <= RECV;
                    count_r   <= {CNT_W{1'b0}};
                    out_valid <= 1'b0;
                    rx_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_crc3_serial_checker.sv
// Scoreboard bench for crc3_serial_checker: each frame's expected result is
// computed by long division and queued when the frame is driven, then popped
// and compared when the checker presents its result.
module tb_crc3_serial_checker;

    localparam int EW = 2;
    localparam logic [16:0] CLEAN = 17'h1A764;

    logic          clk;
    logic          rst_n;
    logic [3:0]    polinom;
    logic          rx_sof;
    logic          rx_bit;
    logic          rx_valid;
    logic          rx_ready;
    logic [13:0]   data_out;
    logic [2:0]    syndrome;
    logic          crc_ok;
    logic          out_valid;
    logic          out_ready;
    logic [EW-1:0] err_cnt;

    typedef struct packed {
        logic [13:0] data;
        logic [2:0]  syn;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests;
    int   n_fail;
    int   err_model;

    crc3_serial_checker #(
        .MSG_LENGTH(17),
        .POLINOMIAL_LENGTH(4),
        .ERR_CNT_W(EW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .polinom(polinom),
        .rx_sof(rx_sof),
        .rx_bit(rx_bit),
        .rx_valid(rx_valid),
        .rx_ready(rx_ready),
        .data_out(data_out),
        .syndrome(syndrome),
        .crc_ok(crc_ok),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .err_cnt(err_cnt)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Polynomial long division remainder of a 17-bit codeword.
    function automatic logic [2:0] crc_rem(input logic [16:0] w, input logic [3:0] p);
        logic [16:0] x;
        x = w;
        for (int i = 16; i >= 3; i--) begin
            if (x[i]) x[i -: 4] = x[i -: 4] ^ p;
        end
        return x[2:0];
    endfunction

    task automatic send_bit(input logic b, input logic sof);
        int guard;
        guard    = 0;
        rx_bit   = b;
        rx_sof   = sof;
        rx_valid = 1'b1;
        while (!rx_ready && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 200) check_eq("rx_ready_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        rx_valid = 1'b0;
        rx_sof   = 1'b0;
        rx_bit   = 1'($urandom_range(1, 0));
    endtask

    task automatic send_frame(input logic [16:0] w, input logic sof, input bit gapped, input int chg_at);
        exp_t e;
        e.data = w[16:3];
        e.syn  = crc_rem(w, polinom);
        exp_q.push_back(e);
        for (int i = 0; i < 17; i++) begin
            if (gapped) begin
                int idle;
                idle = int'($urandom_range(2, 0));
                for (int k = 0; k < idle; k++) begin
                    rx_bit = 1'($urandom_range(1, 0));
                    rx_sof = 1'($urandom_range(1, 0));
                    @(posedge clk); #1;
                end
                rx_sof = 1'b0;
            end
            if (i == chg_at) polinom = 4'b1101;
            send_bit(w[16-i], sof && (i == 0));
        end
        check_eq("lat_out_valid", 32'(out_valid), 32'd1);
        check_eq("lat_rx_ready", 32'(rx_ready), 32'd0);
    endtask

    task automatic collect(input int hold);
        exp_t e;
        int   guard;
        guard = 0;
        while (!out_valid && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 100 || exp_q.size() == 0) begin
            check_eq("result_timeout", 32'(out_valid), 32'd1);
            return;
        end
        e = exp_q.pop_front();
        for (int k = 0; k <= hold; k++) begin
            check_eq("data_out", 32'(data_out), 32'(e.data));
            check_eq("syndrome", 32'(syndrome), 32'(e.syn));
            check_eq("crc_ok", 32'(crc_ok), 32'(e.syn == 3'd0));
            check_eq("hold_rx_ready", 32'(rx_ready), 32'd0);
            check_eq("hold_out_valid", 32'(out_valid), 32'd1);
            if (k < hold) begin
                rx_valid = 1'b1;
                rx_sof   = 1'($urandom_range(1, 0));
                rx_bit   = 1'($urandom_range(1, 0));
                @(posedge clk); #1;
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        rx_valid  = 1'b0;
        rx_sof    = 1'b0;
        if (e.syn != 3'd0 && err_model < (1 << EW) - 1) err_model++;
        check_eq("post_out_valid", 32'(out_valid), 32'd0);
        check_eq("post_rx_ready", 32'(rx_ready), 32'd1);
        check_eq("err_cnt", 32'(err_cnt), 32'(err_model));
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_data"}, 32'(data_out), 32'd0);
        check_eq({tag, "_syn"}, 32'(syndrome), 32'd0);
        check_eq({tag, "_ok"}, 32'(crc_ok), 32'd0);
        check_eq({tag, "_valid"}, 32'(out_valid), 32'd0);
        check_eq({tag, "_err"}, 32'(err_cnt), 32'd0);
        check_eq({tag, "_ready"}, 32'(rx_ready), 32'd1);
    endtask

    initial begin
        clk       = 1'b0;
        rst_n     = 1'b0;
        polinom   = 4'b1011;
        rx_sof    = 1'b0;
        rx_bit    = 1'b0;
        rx_valid  = 1'b0;
        out_ready = 1'b0;
        n_tests   = 0;
        n_fail    = 0;
        err_model = 0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Clean frame, continuous input.
        send_frame(CLEAN, 1'b1, 1'b0, -1);
        collect(0);

        // Single-bit error in the LSB.
        send_frame(CLEAN ^ 17'h00001, 1'b0, 1'b0, -1);
        collect(0);

        // Backpressure: result held for 10 cycles with bits offered.
        send_frame(CLEAN, 1'b0, 1'b0, -1);
        collect(10);

        // Gapped input with a polynomial change mid-frame.
        send_frame(CLEAN, 1'b0, 1'b1, 5);
        collect(0);
        polinom = 4'b1011;

        // Resync: 9 garbage bits, then a frame starting with rx_sof.
        for (int i = 0; i < 9; i++) send_bit(1'($urandom_range(1, 0)), 1'b0);
        send_frame(CLEAN, 1'b1, 1'b0, -1);
        collect(0);
        repeat (5) @(posedge clk);
        #1;
        check_eq("resync_single", 32'(out_valid), 32'd0);

        // Reset mid-frame at bit 8, then a full clean frame.
        for (int i = 0; i < 8; i++) send_bit(CLEAN[16-i], i == 0);
        rst_n = 1'b0;
        #2;
        check_reset_state("midrst");
        err_model = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        send_frame(CLEAN, 1'b0, 1'b0, -1);
        collect(0);

        // Saturation: four corrupted frames drive err_cnt 1,2,3,3.
        for (int i = 0; i < 4; i++) begin
            logic [16:0] flip;
            flip = 17'd1 << (i * 5);
            send_frame(CLEAN ^ flip, 1'b0, 1'b0, -1);
            collect(0);
        end
        check_eq("err_saturated", 32'(err_cnt), 32'd3);
        check_eq("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
